// File: rtl/rle_squash.sv
// rle_squash: run-length encoder on a valid/ready stream.
// Emits {count, value} per run of identical beats; din_last closes the run.
module rle_squash #(
  parameter int DIN = 16,
  parameter int CNT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic [DIN-1:0]       din_data,
  input  logic                 din_last,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [CNT+DIN-1:0]   dout_data,
  output logic                 dout_last
);

  localparam logic [CNT-1:0] MAX = {CNT{1'b1}};
  localparam logic [CNT-1:0] ONE = CNT'(1);

  logic                 run_valid_q, run_valid_d;
  logic [DIN-1:0]       run_data_q, run_data_d;
  logic [CNT-1:0]       run_cnt_q, run_cnt_d;
  logic                 close_pending_q, close_pending_d;
  logic                 out_valid_q, out_valid_d;
  logic [CNT+DIN-1:0]   out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;

  logic slot_free;
  logic accept;
  logic extend;

  assign slot_free = !out_valid_q || dout_ready;
  assign din_ready = rst && slot_free && !close_pending_q;
  assign accept    = din_valid && din_ready;
  assign extend    = (din_data == run_data_q) && (run_cnt_q != MAX);

  always_comb begin
    run_valid_d     = run_valid_q;
    run_data_d      = run_data_q;
    run_cnt_d       = run_cnt_q;
    close_pending_d = close_pending_q;
    out_valid_d     = out_valid_q;
    out_data_d      = out_data_q;
    out_last_d      = out_last_q;
    if (slot_free) begin
      // slot is empty or being drained this cycle
      out_valid_d = 1'b0;
      unique case (1'b1)
        close_pending_q: begin
          out_valid_d     = 1'b1;
          out_data_d      = {run_cnt_q, run_data_q};
          out_last_d      = 1'b1;
          run_valid_d     = 1'b0;
          close_pending_d = 1'b0;
        end
        accept && !run_valid_q: begin
          if (din_last) begin
            out_valid_d = 1'b1;
            out_data_d  = {ONE, din_data};
            out_last_d  = 1'b1;
          end else begin
            run_valid_d = 1'b1;
            run_data_d  = din_data;
            run_cnt_d   = ONE;
          end
        end
        accept && run_valid_q && extend: begin
          if (din_last) begin
            out_valid_d = 1'b1;
            out_data_d  = {run_cnt_q + ONE, din_data};
            out_last_d  = 1'b1;
            run_valid_d = 1'b0;
          end else begin
            run_cnt_d = run_cnt_q + ONE;
          end
        end
        accept && run_valid_q && !extend: begin
          out_valid_d = 1'b1;
          out_data_d  = {run_cnt_q, run_data_q};
          out_last_d  = 1'b0;
          run_data_d  = din_data;
          run_cnt_d   = ONE;
          // the fresh one-beat run is flushed next free cycle
          if (din_last) close_pending_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_valid_q     <= 1'b0;
      run_data_q      <= '0;
      run_cnt_q       <= '0;
      close_pending_q <= 1'b0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_last_q      <= 1'b0;
    end else begin
      run_valid_q     <= run_valid_d;
      run_data_q      <= run_data_d;
      run_cnt_q       <= run_cnt_d;
      close_pending_q <= close_pending_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_last_q      <= out_last_d;
    end
  end

  assign dout_valid = out_valid_q;
  assign dout_data  = out_data_q;
  assign dout_last  = out_last_q;

endmodule

// File: doc/rle_squash.md
Name: rle_squash

Overview:
- Stream run-length encoder on the valid/ready protocol: collapses consecutive identical input beats into one output beat carrying the value and its repeat count.
- The counterpart of the sampling/hold stage: that stage expands sparse data into repeated values; this block removes repetitions before storage or transport.
- A frame-end marker (din_last) closes the current run. Used upstream of FIFOs and links where held or sampled values are repetitive.

Parameters:
- DIN, 16, data width in bits (>=1)
- CNT, 8, count field width in bits (>=1). Maximum run length MAX = 2^CNT-1.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- din_valid  input  1  input beat valid
- din_ready  output  1  input beat accepted when din_valid && din_ready
- din_data  input  DIN  input value
- din_last  input  1  beat is the final beat of the frame
- dout_valid  output  1  output beat valid
- dout_ready  input  1  downstream accepts when dout_valid && dout_ready
- dout_data  output  CNT+DIN  {count[CNT-1:0], value[DIN-1:0]}; count is the run length, 1..MAX
- dout_last  output  1  run closed the frame

Behaviour:
- Reset (rst low, asynchronous):
  - clears run_valid, run_cnt, run_data, close_pending, out_valid, out_data and out_last to 0.
  - dout_valid=0, dout_data=0, dout_last=0.
  - din_ready is forced 0 while rst is low.
- State:
  - run register: run_valid, run_data, run_cnt.
  - close_pending flag.
  - single output register driving the dout_* ports directly: registered outputs, no combinational din->dout path.
- slot_free = !dout_valid || dout_ready.
- din_ready = slot_free && !close_pending. This is combinational from dout_ready and state only, never from din_valid.
- Per cycle, evaluated in priority order and only when slot_free:
  1. close_pending: load output {run_cnt, run_data, last=1}; clear run_valid and close_pending. No input is accepted this cycle.
  2. Accept with !run_valid:
     - if din_last: load output {1, din_data, last=1}; run stays invalid.
     - otherwise: run <= (din_data, 1).
  3. Accept with run_valid, din_data==run_data and run_cnt<MAX:
     - if din_last: load output {run_cnt+1, din_data, 1}; clear run_valid.
     - otherwise: run_cnt <= run_cnt+1.
  4. Accept with run_valid and (mismatch or run_cnt==MAX):
     - load output {run_cnt, run_data, last=0}; run <= (din_data, 1).
     - if din_last: set close_pending. The new single-beat run is emitted next free cycle with last=1.
  5. Otherwise, if a dout handshake occurs: clear dout_valid.
- When not slot_free, all state holds and dout_* stay stable (the valid/ready rule).
- Latency: a run appears on dout one cycle after the accepted beat that terminates it.
- Sustained throughput is one accepted input beat per cycle while dout_ready=1. The only bubble is one din_ready=0 cycle per close_pending event.
- Counts never wrap. The beat that would exceed MAX starts a new run with count 1.
- Output beats are emitted in input order. Total of counts across a frame equals the number of input beats in the frame.
- A run left open without din_last is held indefinitely; there is no timeout.
- Reset mid-frame discards the open run and any pending output beat.

Test Plan:
- Frame A,A,A,B(last) with DIN=16, CNT=8 and dout_ready=1 -> outputs {3,A,0} then {1,B,1}. din_ready drops for exactly one cycle after B is accepted.
- 300 beats of 0x00FF, last on the final beat, CNT=8 -> {255,0x00FF,0} then {45,0x00FF,1}. Counts sum to 300.
- Single beat C with last, idle before -> {1,C,1} one cycle after acceptance. No spurious beats afterward.
- Alternating X,Y,X,Y,... with dout_ready toggled randomly -> one beat per input with count 1 each. dout_data is stable while dout_valid && !dout_ready, and no beats are lost or duplicated (scoreboard).
- Assert rst low asynchronously mid-run (run_cnt=5, dout_valid=1) -> dout_valid=0 immediately. After release, the first output reflects only post-reset beats.
- Back-to-back frames P,P(last) then Q(last) with dout_ready=1 -> {2,P,1}, {1,Q,1} on consecutive cycles with no din_ready bubble.
